// File: rtl/pdf_key_sweeper.sv
// pdf_key_sweeper: issues a contiguous range of 128-bit candidate keys, tracks them in an in-order FIFO, reports the first hit (PDF_KEY_SWEEPER_STATS_EN adds keys_tested).
// Latency: first key offered the cycle after start; a verdict is consumed in its arrival cycle and the result is registered one cycle later.
// Backpressure: key_valid/key_ready handshake; issue stalls while 2^DEPTH_LOG2 keys await verdicts; a pop frees a slot for the following cycle.
module pdf_key_sweeper #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [127:0] base_key,
   input  logic [31:0]  key_count,
   output logic [127:0] key_out,
   output logic         key_valid,
   input  logic         key_ready,
   input  logic         res_valid,
   input  logic         res_hit,
   output logic         busy,
   output logic         done,
   output logic         found,
   output logic [127:0] match_key,
   output logic         proto_err,
   output logic [31:0]  keys_tested
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0] PTR_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [127:0]        cur_key_q, cur_key_d;
   logic [31:0]         remaining_q, remaining_d;
   logic                found_q, found_d;
   logic [127:0]        match_key_q, match_key_d;
   logic                proto_err_q, proto_err_d;
   logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
   logic [127:0]        fifo_mem_q [DEPTH];

   logic [DEPTH_LOG2:0] occ;
   logic                fifo_empty, fifo_full, active, push, pop;
   logic [127:0]        head_key;

   // FIFO status and handshake qualifiers; push uses the pre-pop full flag
   always_comb begin
      occ        = wr_ptr_q - rd_ptr_q;
      fifo_empty = (occ == '0);
      fifo_full  = (occ == PTR_FULL);
      active     = (state_q == S_RUN) || (state_q == S_DRAIN);
      key_valid  = (state_q == S_RUN) && !fifo_full;
      push       = key_valid && key_ready;
      pop        = active && res_valid && !fifo_empty;
      head_key   = fifo_mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
   end

   // Next-state: key issue, verdict consumption, sweep sequencing
   always_comb begin
      state_d     = state_q;
      cur_key_d   = cur_key_q;
      remaining_d = remaining_q;
      found_d     = found_q;
      match_key_d = match_key_q;
      proto_err_d = proto_err_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;

      // a verdict with nothing outstanding is a checker protocol violation
      if (res_valid && fifo_empty) begin
         proto_err_d = 1'b1;
      end
      if (push) begin
         wr_ptr_d    = wr_ptr_q + PTR_ONE;
         cur_key_d   = cur_key_q + 128'd1;
         remaining_d = remaining_q - 32'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (res_hit && !found_q) begin
            found_d     = 1'b1;
            match_key_d = head_key;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_key_d   = base_key;
               remaining_d = key_count;
               found_d     = 1'b0;
               match_key_d = '0;
               proto_err_d = 1'b0;
               wr_ptr_d    = '0;
               rd_ptr_d    = '0;
               state_d     = (key_count == 32'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               state_d  = S_IDLE;
            end else if ((push && remaining_q == 32'd1) || (pop && res_hit)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               state_d  = S_IDLE;
            end else if (fifo_empty || (pop && occ == PTR_ONE)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cur_key_q   <= '0;
         remaining_q <= '0;
         found_q     <= 1'b0;
         match_key_q <= '0;
         proto_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_key_q   <= cur_key_d;
         remaining_q <= remaining_d;
         found_q     <= found_d;
         match_key_q <= match_key_d;
         proto_err_q <= proto_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Outstanding-key storage; contents are don't-care while the pointers say empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= cur_key_q;
      end
   end

`ifdef PDF_KEY_SWEEPER_STATS_EN
   logic [31:0] keys_tested_q, keys_tested_d;

   // Saturating count of verdicts consumed in the current sweep
   always_comb begin
      keys_tested_d = keys_tested_q;
      if (state_q == S_IDLE && start) begin
         keys_tested_d = '0;
      end else if (pop && keys_tested_q != '1) begin
         keys_tested_d = keys_tested_q + 32'd1;
      end
   end

   // Statistics register
   always_ff @(posedge clk) begin
      if (rst) begin
         keys_tested_q <= '0;
      end else begin
         keys_tested_q <= keys_tested_d;
      end
   end

   assign keys_tested = keys_tested_q;
`else
   assign keys_tested = '0;
`endif

   assign key_out   = cur_key_q;
   assign busy      = active;
   assign done      = (state_q == S_DONE);
   assign found     = found_q;
   assign match_key = match_key_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_pdf_key_sweeper.sv
// Bench for pdf_key_sweeper: directed scenarios plus randomized sweeps scored against a queue-based model.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at the same point.
// The model tracks outstanding keys as a queue and derives valid/done/result expectations from counts.
module tb_pdf_key_sweeper;

   localparam int FIFO_DEPTH = 8;
`ifdef PDF_KEY_SWEEPER_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, start, abort, key_ready, res_valid, res_hit;
   logic [127:0] base_key;
   logic [31:0]  key_count;
   logic [127:0] key_out, match_key;
   logic         key_valid, busy, done, found, proto_err;
   logic [31:0]  keys_tested;

   int n_tests = 0;
   int n_fail  = 0;

   pdf_key_sweeper dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_key(base_key), .key_count(key_count),
      .key_out(key_out), .key_valid(key_valid), .key_ready(key_ready),
      .res_valid(res_valid), .res_hit(res_hit),
      .busy(busy), .done(done), .found(found), .match_key(match_key),
      .proto_err(proto_err), .keys_tested(keys_tested)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] kt_exp(input int n);
      return STATS_EN ? {96'd0, 32'(n)} : 128'd0;
   endfunction

   // One sweep with random ready/verdict timing; keys at offset hit_off and hit_off+1 are hits.
   task automatic sweep(input logic [127:0] base, input int count, input int hit_off,
                        input int rdy_pct, input int lat, input int res_pct);
      logic [127:0] q_key[$];
      int           q_cyc[$];
      int           q_off[$];
      logic [127:0] next_key, exp_match;
      bit           exp_found, hit_seen, finished, fin_prev, exp_vld, xfer;
      int           issued, returned, cyc;
      next_key = base; exp_match = '0; exp_found = 0; hit_seen = 0; fin_prev = 0;
      issued = 0; returned = 0; cyc = 0;
      base_key = base; key_count = count; start = 1'b1;
      tick();
      start = 1'b0;
      forever begin
         key_ready = ($urandom_range(99) < rdy_pct);
         res_valid = 1'b0;
         res_hit   = 1'b0;
         if (q_key.size() != 0 && cyc >= q_cyc[0] + lat && $urandom_range(99) < res_pct) begin
            res_valid = 1'b1;
            res_hit   = (hit_off >= 0) && (q_off[0] == hit_off || q_off[0] == hit_off + 1);
         end
         chk1("done", done, fin_prev);
         if (fin_prev) break;
         exp_vld = !hit_seen && issued < count && q_key.size() < FIFO_DEPTH;
         chk1("key_valid", key_valid, exp_vld);
         chk1("busy", busy, 1'b1);
         if (exp_vld) chk128("key_out", key_out, next_key);
         finished = hit_seen || issued == count;
         xfer = key_valid && key_ready;
         if (res_valid) begin
            if (res_hit && !exp_found) begin
               exp_found = 1;
               exp_match = q_key[0];
               hit_seen  = 1;
            end
            void'(q_key.pop_front());
            void'(q_cyc.pop_front());
            void'(q_off.pop_front());
            returned++;
         end
         if (xfer) begin
            q_key.push_back(next_key);
            q_cyc.push_back(cyc);
            q_off.push_back(issued);
            next_key = next_key + 128'd1;
            issued++;
         end
         fin_prev = finished && q_key.size() == 0;
         tick();
         cyc++;
         if (cyc > 4000) begin
            chk1("sweep_timeout_done", done, 1'b1);
            break;
         end
      end
      key_ready = 1'b0; res_valid = 1'b0; res_hit = 1'b0;
      chk1("found", found, exp_found);
      chk128("match_key", match_key, exp_match);
      chk128("keys_tested", {96'd0, keys_tested}, kt_exp(returned));
      chk1("proto_err_clear", proto_err, 1'b0);
      chk1("busy_in_done", busy, 1'b0);
      tick();
      chk1("done_one_cycle", done, 1'b0);
      chk1("found_held", found, exp_found);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b0;
      res_valid = 1'b0; res_hit = 1'b0; base_key = '0; key_count = '0;
      repeat (3) tick();
      // reset values
      chk1("rst_key_valid", key_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_found", found, 1'b0);
      chk1("rst_proto_err", proto_err, 1'b0);
      chk128("rst_key_out", key_out, 128'd0);
      chk128("rst_match_key", match_key, 128'd0);
      chk128("rst_keys_tested", {96'd0, keys_tested}, 128'd0);
      rst = 1'b0;
      tick();

      // plain sweep, hit mid-range with a second later hit, wrap-around
      sweep(128'h10, 4, -1, 100, 3, 100);
      sweep(128'h100, 16, 3, 100, 3, 100);
      sweep({128{1'b1}}, 2, -1, 100, 2, 100);

      // full FIFO and backpressure
      base_key = 128'h500; key_count = 20; key_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();
      chk1("full_key_valid", key_valid, 1'b0);
      chk128("full_key_out", key_out, 128'h508);
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk1("slot_key_valid", key_valid, 1'b1);
      tick();
      chk1("refull_key_valid", key_valid, 1'b0);
      chk128("refull_key_out", key_out, 128'h509);
      res_valid = 1'b1; key_ready = 1'b0;
      tick();
      res_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk1("stall_key_valid", key_valid, 1'b1);
         chk128("stall_key_out", key_out, 128'h509);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk1("bp_abort_busy", busy, 1'b0);
      chk128("bp_keys_tested_held", {96'd0, keys_tested}, kt_exp(2));

      // abort after two transfers
      base_key = 128'h600; key_count = 10; start = 1'b1;
      tick();
      start = 1'b0; key_ready = 1'b1;
      tick();
      tick();
      chk128("abort_pre_key_out", key_out, 128'h602);
      abort = 1'b1; key_ready = 1'b0;
      tick();
      abort = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk1("abort_key_valid", key_valid, 1'b0);
      // a verdict now finds the flushed FIFO empty
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk1("proto_err_set", proto_err, 1'b1);
      chk1("abort_no_done", done, 1'b0);

      // zero-count sweep also clears proto_err
      key_count = 0; start = 1'b1;
      tick();
      start = 1'b0;
      chk1("zero_done", done, 1'b1);
      chk1("zero_key_valid", key_valid, 1'b0);
      chk1("zero_proto_err_cleared", proto_err, 1'b0);
      tick();
      chk1("zero_done_pulse", done, 1'b0);
      chk1("zero_key_valid_after", key_valid, 1'b0);

      // reset mid-sweep after a hit
      base_key = 128'h700; key_count = 20; start = 1'b1;
      tick();
      start = 1'b0; key_ready = 1'b1;
      repeat (3) tick();
      key_ready = 1'b0; res_valid = 1'b1; res_hit = 1'b1;
      tick();
      res_valid = 1'b0; res_hit = 1'b0;
      chk1("pre_rst_found", found, 1'b1);
      chk128("pre_rst_match", match_key, 128'h700);
      chk1("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("mid_rst_key_valid", key_valid, 1'b0);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_done", done, 1'b0);
      chk1("mid_rst_found", found, 1'b0);
      chk1("mid_rst_proto_err", proto_err, 1'b0);
      chk128("mid_rst_key_out", key_out, 128'd0);
      chk128("mid_rst_match_key", match_key, 128'd0);
      chk128("mid_rst_keys_tested", {96'd0, keys_tested}, 128'd0);
      tick();

      // randomized sweeps
      for (int s = 0; s < 14; s++) begin
         logic [127:0] rb;
         int           rc, rh;
         rb = {$urandom, $urandom, $urandom, $urandom};
         rc = int'($urandom_range(1, 24));
         rh = ($urandom_range(1) == 1) ? int'($urandom_range(0, rc + 2)) : -1;
         sweep(rb, rc, rh, int'($urandom_range(30, 100)), int'($urandom_range(1, 5)),
               int'($urandom_range(40, 100)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pdf_key_sweeper.md
# pdf_key_sweeper

Candidate-key source for the PDF password search path. Enumerates a contiguous range of 128-bit keys from a base value, issues them to the decryption core over a valid/ready handshake, and keeps the outstanding keys in an in-order FIFO. Consumes the per-key verdicts returned by the header checker, stops issuing on the first hit, and reports the matching key once every outstanding verdict has been drained.

## Interface
- `DEPTH_LOG2`, default 3: outstanding-key FIFO holds 2^DEPTH_LOG2 entries.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; launches a sweep. Sampled only in IDLE.
- `abort` in 1: cancels the sweep. Sampled in RUN and DRAIN.
- `base_key` in 128: first candidate key, sampled with `start`.
- `key_count` in 32: number of keys to issue, sampled with `start`.
- `key_out` in/out: out 128: current candidate key.
- `key_valid` out 1: `key_out` is offered to the decryption core.
- `key_ready` in 1: core accepts `key_out`. A transfer is `key_valid & key_ready`.
- `res_valid` in 1: the checker returns one verdict, in issue order.
- `res_hit` in 1: the verdict is a match. Valid with `res_valid`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse on sweep completion. Not pulsed on abort.
- `found` out 1: the last completed sweep had a hit. Held until the next `start` or `rst`.
- `match_key` out 128: the key that matched. Held with `found`.
- `proto_err` out 1: sticky flag; set by `res_valid` while the FIFO is empty. Cleared by `start` or `rst`.
- `keys_tested` out 32: count of verdicts consumed in the current sweep. Present only with `PDF_KEY_SWEEPER_STATS_EN`.

## Operation
The block is a state machine with four states: IDLE, RUN, DRAIN, DONE.

- **IDLE**
  - `start` loads `cur_key` from `base_key` and `remaining` from `key_count`, clears `found`, `match_key`, `proto_err` and the FIFO.
  - If `key_count == 0`, go to DONE; otherwise go to RUN.
- **RUN**
  - `key_valid` is high whenever the FIFO is not full. `key_out` is `cur_key`.
  - On a transfer: push `cur_key` into the FIFO, set `cur_key` to `cur_key + 1` (modulo 2^128, so all-ones wraps to 0), and decrement `remaining`.
  - The transfer that brings `remaining` to 0 moves the block to DRAIN.
- **Verdicts** (RUN and DRAIN)
  - On each `res_valid`, pop the FIFO head.
  - If `res_hit` is set and `found` is 0, set `found` and capture the popped key into `match_key`.
  - A hit in RUN moves the block to DRAIN. Keys already issued still have their verdicts consumed.
  - Later hits are ignored: the first hit wins.
- **DRAIN**
  - `key_valid` is 0.
  - When the FIFO is empty, including the case where it empties through a pop in this cycle, go to DONE.
- **DONE**
  - `done` is high for exactly this one cycle; the next state is IDLE.
- **abort** in RUN or DRAIN: go to IDLE next cycle, flush the FIFO, leave `found` and `match_key` as they are, no `done` pulse.
- **Simultaneous push and pop** in one cycle: both are performed and the occupancy is unchanged. This is allowed when the FIFO is full, because push is gated by the pre-pop full flag.
- **`res_valid` while the FIFO is empty**: no pop, set `proto_err`, state unchanged.
- **`start` outside IDLE**: ignored.

## Timing
- **Reset values**: state IDLE; `key_valid`, `busy`, `done`, `found`, `proto_err` are 0; `key_out`, `match_key`, `keys_tested` are 0; FIFO empty.
- **Start to first key**: with `start` at cycle T, `key_valid` is high at T+1 and `busy` is high at T+1.
- **Key rate**: one key per cycle when `key_ready` is held high and the FIFO does not fill.
- **Handshake rules**:
  - `key_out` is stable while `key_valid` is high and `key_ready` is low.
  - `key_valid` never drops without a transfer, except on a hit, on `abort`, or on `rst`.
- **Verdict to result**: a hit verdict at cycle T updates `match_key` and `found` at T+1 (registered).
- **Completion**: `done` is asserted the cycle after the FIFO becomes empty in DRAIN.
- **Zero-count sweep**: with `key_count == 0`, `done` fires at T+1 and `key_valid` stays low.

## Configuration
- **Macro**: `PDF_KEY_SWEEPER_STATS_EN`.
- **Defined**:
  - `keys_tested` is a 32-bit counter, cleared on `start`, incremented on each accepted (popped) verdict, and saturating at all-ones.
  - It is held after DONE or abort.
- **Undefined**: the `keys_tested` port is still present and tied to 0; no counter logic is synthesized.

## Test plan
- **Plain sweep**: `base_key=0x10`, `key_count=4`, `key_ready=1`, verdicts returned 3 cycles after issue, none a hit.
  - Keys 0x10 to 0x13 are issued on consecutive cycles.
  - `done` pulses one cycle after the 4th verdict; `found=0`; `keys_tested=4`.
- **Hit mid-range**: `base_key=0x100`, `key_count=16`; the verdict for 0x103 is a hit.
  - Issuing stops on the hit; all outstanding verdicts are drained; `found=1`; `match_key=0x103`.
  - A second hit on 0x104 does not change `match_key`.
- **Backpressure and full FIFO**: `DEPTH_LOG2=3`, no verdicts returned, `key_ready=1`.
  - After 8 transfers `key_valid=0`.
  - One verdict gives exactly one further transfer.
  - `key_out` is stable while `key_ready=0`.
- **Wrap-around**: `base_key` is all-ones, `key_count=2`.
  - Issued keys are 0xFF..FF then 0x0.
  - `done` follows once both verdicts have returned.
- **Abort and reset**:
  - `abort` in RUN after 2 transfers: next cycle IDLE, `busy=0`, no `done`, FIFO empty.
  - Asserting `rst` mid-sweep returns every output to its reset value.
- **Protocol error and zero count**:
  - `res_valid=1` in IDLE sets `proto_err=1`; it is cleared by the next `start`.
  - `key_count=0` gives `done` at T+1 with `key_valid` never high.
